// File: rtl/wb_stage_if.sv
// MEM/WB handoff bundle: the fields the memory stage presents to write-back.
interface wb_stage_if;
  logic        mw_valid;
  logic        mw_regwrite;
  logic [4:0]  mw_rd;
  logic [1:0]  mw_wbsel;
  logic [31:0] mw_alu_result;
  logic [31:0] mw_load_data;
  logic [2:0]  mw_funct3;
  logic [31:0] mw_pc;

  // Memory stage side drives the bundle.
  modport master (
    output mw_valid, mw_regwrite, mw_rd, mw_wbsel,
           mw_alu_result, mw_load_data, mw_funct3, mw_pc
  );

  // Write-back stage side consumes it.
  modport slave (
    input  mw_valid, mw_regwrite, mw_rd, mw_wbsel,
           mw_alu_result, mw_load_data, mw_funct3, mw_pc
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: holds the retiring instruction, selects/extends the
// result, decodes a one-hot register-file write enable and counts retires.
module wb_stage #(
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  wb_stage_if.slave            mw,
  output logic [31:0]          rf_wdata,
  output logic [31:0]          rf_wen,
  output logic [4:0]           wb_rd,
  output logic                 wb_valid,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // WB stage register
  logic        valid_q,    valid_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  rd_q,       rd_d;
  logic [1:0]  wbsel_q,    wbsel_d;
  logic [31:0] alu_q,      alu_d;
  logic [31:0] load_q,     load_d;
  logic [2:0]  funct3_q,   funct3_d;
  logic [31:0] pc_q,       pc_d;

  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 retire;

  logic [31:0] load_ext;
  logic [31:0] pc_plus4;

  // Next-state for the stage register: flush beats stall beats capture.
  // On flush only valid is cleared; the payload is don't-care so it holds.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    rd_d       = rd_q;
    wbsel_d    = wbsel_q;
    alu_d      = alu_q;
    load_d     = load_q;
    funct3_d   = funct3_q;
    pc_d       = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d    = mw.mw_valid;
      regwrite_d = mw.mw_regwrite;
      rd_d       = mw.mw_rd;
      wbsel_d    = mw.mw_wbsel;
      alu_d      = mw.mw_alu_result;
      load_d     = mw.mw_load_data;
      funct3_d   = mw.mw_funct3;
      pc_d       = mw.mw_pc;
    end
  end

  // Stage register update; reset clears every field so outputs read as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= 5'd0;
      wbsel_q    <= 2'b00;
      alu_q      <= 32'd0;
      load_q     <= 32'd0;
      funct3_q   <= 3'd0;
      pc_q       <= 32'd0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wbsel_q    <= wbsel_d;
      alu_q      <= alu_d;
      load_q     <= load_d;
      funct3_q   <= funct3_d;
      pc_q       <= pc_d;
    end
  end

  // The occupant leaves the stage when it is not held, or when it is
  // flushed out (its write still lands on that same edge).
  always_comb begin
    retire    = valid_q && (!stall || flush);
    instret_d = instret_q;
    if (retire) begin
      instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end
  end

  // Retired-instruction counter; wraps silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  // Load data sizing and sign/zero extension; unlisted codes pass the word.
  always_comb begin
    load_ext = load_q;
    unique case (funct3_q)
      F3_LB:   load_ext = {{24{load_q[7]}}, load_q[7:0]};
      F3_LH:   load_ext = {{16{load_q[15]}}, load_q[15:0]};
      F3_LBU:  load_ext = {24'd0, load_q[7:0]};
      F3_LHU:  load_ext = {16'd0, load_q[15:0]};
      default: load_ext = load_q;
    endcase
  end

  assign pc_plus4 = pc_q + 32'd4;

  // Result select; 11 aliases to the ALU path.
  always_comb begin
    rf_wdata = alu_q;
    case (wbsel_q)
      SEL_ALU:  rf_wdata = alu_q;
      SEL_LOAD: rf_wdata = load_ext;
      SEL_PC4:  rf_wdata = pc_plus4;
      default:  rf_wdata = alu_q;
    endcase
  end

  // One-hot write enable; x0 is never written so bit 0 stays low.
  always_comb begin
    rf_wen = 32'd0;
    if (valid_q && regwrite_q && (rd_q != 5'd0)) begin
      rf_wen[rd_q] = 1'b1;
    end
  end

  assign wb_rd    = rd_q;
  assign wb_valid = valid_q;
  assign instret  = instret_q;

  // The register file relies on at most one write enable per cycle.
  always_ff @(posedge clk) begin
    assert ($onehot0(rf_wen)) else $error("rf_wen not one-hot: %h", rf_wen);
    assert (rf_wen[0] == 1'b0) else $error("rf_wen[0] asserted");
  end

endmodule

// File: tb/tb_wb_stage.sv
// Randomized + directed bench for wb_stage against a slot-level reference model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] rf_wdata, rf_wen, rf_wdata4, rf_wen4;
  logic [4:0]  wb_rd, wb_rd4;
  logic        wb_valid, wb_valid4;
  logic [63:0] instret;
  logic [3:0]  instret4;

  wb_stage_if mw_if ();

  wb_stage #(.INSTRET_W(64)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .mw(mw_if.slave),
    .rf_wdata(rf_wdata), .rf_wen(rf_wen), .wb_rd(wb_rd), .wb_valid(wb_valid),
    .instret(instret)
  );

  wb_stage #(.INSTRET_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .mw(mw_if.slave),
    .rf_wdata(rf_wdata4), .rf_wen(rf_wen4), .wb_rd(wb_rd4), .wb_valid(wb_valid4),
    .instret(instret4)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the instruction sitting in WB plus a retire count.
  typedef struct {
    bit        v;
    bit        rw;
    bit [4:0]  rd;
    bit [1:0]  sel;
    bit [31:0] alu;
    bit [31:0] ld;
    bit [2:0]  f3;
    bit [31:0] pc;
  } slot_t;

  slot_t           m;
  bit              m_known;   // payload is meaningful (valid or freshly reset)
  longint unsigned m_ret;

  function automatic bit [31:0] ref_result(slot_t s);
    byte     sb;
    shortint sh;
    if (s.sel == 2'd2) return s.pc + 32'd4;
    if (s.sel != 2'd1) return s.alu;
    case (s.f3)
      3'd0: begin sb = s.ld[7:0];  return 32'(int'(sb)); end
      3'd1: begin sh = s.ld[15:0]; return 32'(int'(sh)); end
      3'd4: return s.ld % 32'd256;
      3'd5: return s.ld % 32'd65536;
      default: return s.ld;
    endcase
  endfunction

  function automatic bit [31:0] ref_wen(slot_t s);
    if (s.v && s.rw && s.rd != 0) return 32'd1 << s.rd;
    return 32'd0;
  endfunction

  function automatic slot_t inputs_slot();
    slot_t s;
    s.v = mw_if.mw_valid;   s.rw = mw_if.mw_regwrite; s.rd = mw_if.mw_rd;
    s.sel = mw_if.mw_wbsel; s.alu = mw_if.mw_alu_result;
    s.ld = mw_if.mw_load_data; s.f3 = mw_if.mw_funct3; s.pc = mw_if.mw_pc;
    return s;
  endfunction

  task automatic set_in(input bit v, input bit rw, input bit [4:0] rd, input bit [1:0] sel,
                        input bit [31:0] alu, input bit [31:0] ld, input bit [2:0] f3,
                        input bit [31:0] pc);
    mw_if.mw_valid = v;   mw_if.mw_regwrite = rw; mw_if.mw_rd = rd;
    mw_if.mw_wbsel = sel; mw_if.mw_alu_result = alu; mw_if.mw_load_data = ld;
    mw_if.mw_funct3 = f3; mw_if.mw_pc = pc;
  endtask

  // Advance one edge with the inputs currently applied, then check against the model.
  task automatic cycle();
    slot_t nxt;
    nxt = inputs_slot();
    if (reset) begin
      m = '{default: '0};
      m_known = 1'b1;
      m_ret = 0;
    end else begin
      if (m.v && (!stall || flush)) m_ret++;
      if (flush) begin
        m.v = 1'b0;
        m_known = 1'b0;
      end else if (!stall) begin
        m = nxt;
        m_known = m.v;
      end
    end
    @(posedge clk);
    #1;
    chk("wb_valid", 64'(wb_valid), 64'(m.v));
    chk("rf_wen", 64'(rf_wen), 64'(ref_wen(m)));
    chk("instret", instret, m_ret);
    chk("instret4", 64'(instret4), 64'(m_ret % 16));
    if (m_known) begin
      chk("rf_wdata", 64'(rf_wdata), 64'(ref_result(m)));
      chk("wb_rd", 64'(wb_rd), 64'(m.rd));
    end
  endtask

  task automatic bubble();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1; stall = 0; flush = 0;
    bubble();
    cycle();
    chk("rst_wen", 64'(rf_wen), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_rd", 64'(wb_rd), 64'd0);
    chk("rst_valid", 64'(wb_valid), 64'd0);
    chk("rst_instret", instret, 64'd0);
    reset = 0;
  endtask

  bit [2:0]    f3s   [5] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd2};
  bit [31:0]   ldexp [5] = '{32'hFFFFFFF0, 32'hFFFF80F0, 32'h000000F0, 32'h000080F0, 32'h000080F0};

  initial begin
    reset = 1; stall = 0; flush = 0;
    bubble();
    m = '{default: '0}; m_known = 1'b0; m_ret = 0;
    do_reset();

    // ALU write to x5
    set_in(1, 1, 5'd5, 2'b00, 32'h12345678, 0, 0, 32'h100);
    cycle();
    chk("alu_wen", 64'(rf_wen), 64'h20);
    chk("alu_wdata", 64'(rf_wdata), 64'h12345678);
    chk("alu_ret_before", instret, 64'd0);
    bubble();
    cycle();
    chk("alu_ret_after", instret, 64'd1);

    // Load extension variants
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 5'd7, 2'b01, 32'hDEADBEEF, 32'h000080F0, f3s[i], 0);
      cycle();
      chk($sformatf("load_f3_%0d", f3s[i]), 64'(rf_wdata), 64'(ldexp[i]));
    end

    // Write to x0 retires without a write enable; PC+4 wraps
    set_in(1, 1, 5'd0, 2'b00, 32'hAAAA5555, 0, 0, 0);
    cycle();
    chk("x0_wen", 64'(rf_wen), 64'd0);
    set_in(1, 1, 5'd9, 2'b10, 0, 0, 0, 32'hFFFFFFFC);
    cycle();
    chk("x0_retired", instret, 64'd7);
    chk("pc4_wrap", 64'(rf_wdata), 64'd0);
    chk("pc4_wen", 64'(rf_wen), 64'h200);

    // Stall holds outputs and counter for three edges
    set_in(1, 1, 5'd3, 2'b00, 32'h55555555, 0, 0, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_wdata", 64'(rf_wdata), 64'd0);
      chk("stall_wen", 64'(rf_wen), 64'h200);
      chk("stall_instret", instret, 64'd7);
    end
    // Stall + flush: flush wins, occupant retires
    flush = 1;
    cycle();
    chk("sf_instret", instret, 64'd8);
    chk("sf_valid", 64'(wb_valid), 64'd0);
    chk("sf_wen", 64'(rf_wen), 64'd0);
    stall = 0; flush = 0;

    // Reset while stalled with a writing instruction in WB
    set_in(1, 1, 5'd12, 2'b00, 32'h0F0F0F0F, 0, 0, 0);
    cycle();
    chk("pre_rst_wen", 64'(rf_wen), 64'h1000);
    stall = 1; reset = 1;
    cycle();
    chk("midrst_wen", 64'(rf_wen), 64'd0);
    chk("midrst_valid", 64'(wb_valid), 64'd0);
    chk("midrst_instret", instret, 64'd0);
    reset = 0; stall = 0;

    // 16 retires on the 4-bit counter wrap to zero
    for (int i = 0; i < 17; i++) begin
      set_in(1, 1, 5'(i + 1), 2'b00, 32'(i), 0, 0, 0);
      cycle();
      if (i == 15) chk("wrap4_max", 64'(instret4), 64'hF);
    end
    chk("wrap4_zero", 64'(instret4), 64'd0);
    chk("wrap64_16", instret, 64'd16);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom), 2'($urandom),
             $urandom, $urandom, 3'($urandom), $urandom);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 0; stall = 0; flush = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter INSTRET_W, default 64, width of the retired-instruction counter.
REQ-002 The block SHALL have exactly one clock, clk; reset is synchronous and active-high, named reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 stall  input  1  hold WB stage register.
REQ-006 flush  input  1  load bubble into WB stage register.
REQ-007 mw_valid  input  1  MEM/WB instruction valid.
REQ-008 mw_regwrite  input  1  instruction writes rd.
REQ-009 mw_rd  input  5  destination register index.
REQ-010 mw_wbsel  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 ALU.
REQ-011 mw_alu_result  input  32  ALU result.
REQ-012 mw_load_data  input  32  memory read word, already right-aligned to bit 0.
REQ-013 mw_funct3  input  3  load size/sign code.
REQ-014 mw_pc  input  32  instruction PC.
REQ-015 rf_wdata  output  32  write data broadcast to every register bit cell.
REQ-016 rf_wen  output  32  one-hot per-register write enable; bit n drives register n.
REQ-017 wb_rd  output  5  rd of instruction in WB, for forwarding.
REQ-018 wb_valid  output  1  WB stage holds a valid instruction.
REQ-019 instret  output  INSTRET_W  retired-instruction count.

Function
REQ-020 WB stage register SHALL hold valid, regwrite, rd, wbsel, alu_result, load_data, funct3, pc.
REQ-021 Edge update priority SHALL be: reset > flush (valid<=0, other fields don't-care) > stall (hold) > capture all mw_* fields.
REQ-022 rf_wdata, rf_wen, wb_rd, wb_valid SHALL be combinational from the WB register only; zero latency from WB register, one cycle from mw_* inputs.
REQ-023 wbsel 00/11: rf_wdata = alu_result; 10: rf_wdata = pc + 4, modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-024 wbsel 01, funct3 000: sign-extend bits 7:0; 001: sign-extend 15:0; 100: zero-extend 7:0; 101: zero-extend 15:0; 010 and all other codes: full 32-bit word.
REQ-025 rf_wen[n] = 1 only when valid=1, regwrite=1, rd=n, and n!=0; rf_wen[0] SHALL be constant 0.
REQ-026 rf_wen SHALL be one-hot or all-zero in every cycle.
REQ-027 rf_wen stays asserted while stall holds a valid writing instruction; the repeated write of identical data is permitted.
REQ-028 An instruction retires at an edge where wb_valid=1 and (stall=0 or flush=1); instret SHALL then increment by exactly 1.
REQ-029 instret SHALL wrap from 2^INSTRET_W-1 to 0 without a flag.
REQ-030 stall and flush together: flush wins; current WB instruction retires (its write occurs at that edge), register becomes bubble.
REQ-031 Bubbles (valid=0) SHALL never assert rf_wen nor increment instret, regardless of regwrite/rd contents.

Reset
REQ-032 At the first edge with reset=1: WB register valid=0, all fields 0; instret=0.
REQ-033 During and after reset until first capture: rf_wen=0, rf_wdata=0x00000000, wb_rd=0, wb_valid=0.
REQ-034 Reset asserted mid-stall or mid-flush SHALL override both; the in-flight WB instruction SHALL NOT retire.

Verification
REQ-035 ALU write: mw_valid=1, regwrite=1, rd=5, wbsel=00, alu=0x12345678 -> next cycle rf_wen=0x00000020, rf_wdata=0x12345678; instret +1 on following edge.
REQ-036 Load extension: load_data=0x000080F0, funct3 000/001/100/101/010 -> rf_wdata 0xFFFFFFF0/0xFFFF80F0/0x000000F0/0x000080F0/0x000080F0.
REQ-037 x0 and PC+4: rd=0, regwrite=1 -> rf_wen=0 but instret increments; wbsel=10, pc=0xFFFFFFFC -> rf_wdata=0x00000000.
REQ-038 Stall/flush: stall=1 for 3 cycles -> wb outputs frozen, instret unchanged; stall=1,flush=1 -> instret +1, wb_valid=0 next cycle, rf_wen=0.
REQ-039 Reset mid-operation: valid writing instruction in WB, reset=1 with stall=1 -> next cycle rf_wen=0, wb_valid=0, instret=0.
REQ-040 Wrap: preload instret to all-ones via retire sequence (INSTRET_W=4 build, 16 retires) -> instret=0.
